// File: rtl/branch_pred_pkg.sv
// Shared types and constants for the branch predictor driver.
package branch_pred_pkg;

    localparam int unsigned ADDR_W             = 8;
    localparam int unsigned CNT_W              = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 63;
    localparam int unsigned DEF_HIST_BITS      = 8;
    localparam int unsigned DEF_HIST_LAT       = 2;

    typedef enum logic [2:0] {
        ST_WAIT_MEM,
        ST_IDLE,
        ST_ASSERT,
        ST_WAIT_PRED,
        ST_WAIT_DONE,
        ST_RELEASE,
        ST_HIST
    } state_t;

    // One branch record as presented to the predictor.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              taken;
    } trace_rec_t;

    // Saturating increment for the statistics counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/branch_pred_driver_if.sv
// Trace handshake and predictor-facing bus of the branch predictor driver.
// master: the driver; slave: trace source plus predictor.
interface branch_pred_driver_if;

    logic                               trace_valid;
    logic                               trace_ready;
    logic [branch_pred_pkg::ADDR_W-1:0] trace_addr;
    logic                               trace_taken;

    logic [branch_pred_pkg::ADDR_W-1:0] bp_inst_addr;
    logic                               bp_direction;
    logic                               bp_new_data_avail;
    logic                               bp_pred_ready;
    logic                               bp_prediction;
    logic                               bp_training_done;
    logic                               bp_mem_reset_done;
    logic                               bp_hist_bit;
    logic                               bp_hist_req;

    modport master (
        input  trace_valid, trace_addr, trace_taken,
        input  bp_pred_ready, bp_prediction, bp_training_done,
        input  bp_mem_reset_done, bp_hist_bit,
        output trace_ready, bp_inst_addr, bp_direction,
        output bp_new_data_avail, bp_hist_req
    );

    modport slave (
        output trace_valid, trace_addr, trace_taken,
        output bp_pred_ready, bp_prediction, bp_training_done,
        output bp_mem_reset_done, bp_hist_bit,
        input  trace_ready, bp_inst_addr, bp_direction,
        input  bp_new_data_avail, bp_hist_req
    );

endinterface

// File: rtl/branch_pred_hist_rx.sv
// History readback receiver: waits HIST_LAT cycles after start, then shifts
// HIST_BITS serial bits LSB-first and pulses hist_valid with the word.
// Requires HIST_LAT >= 1 and HIST_BITS >= 2.
module branch_pred_hist_rx #(
    parameter int unsigned HIST_BITS = 8,
    parameter int unsigned HIST_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 hist_bit,
    output logic                 done_c,
    output logic                 hist_valid,
    output logic [HIST_BITS-1:0] hist_data
);

    localparam int unsigned DLY_W = (HIST_LAT < 1) ? 1 : $clog2(HIST_LAT + 1);
    localparam int unsigned BIT_W = (HIST_BITS < 2) ? 1 : $clog2(HIST_BITS);

    logic                 active_q;
    logic [DLY_W-1:0]     dly_q;
    logic [BIT_W-1:0]     bit_q;
    logic [HIST_BITS-1:0] shift_q;
    logic [HIST_BITS-1:0] shift_c;
    logic                 sample_c;

    assign sample_c = active_q && (dly_q == DLY_W'(HIST_LAT));
    assign done_c   = sample_c && (bit_q == BIT_W'(HIST_BITS - 1));
    assign shift_c  = {hist_bit, shift_q[HIST_BITS-1:1]};

    // Delay count, bit count and shift register; the word is published on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            dly_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            hist_valid <= 1'b0;
            hist_data  <= '0;
        end else begin
            hist_valid <= 1'b0;
            if (start) begin
                active_q <= 1'b1;
                dly_q    <= DLY_W'(1);
                bit_q    <= '0;
            end else if (active_q) begin
                if (!sample_c) begin
                    dly_q <= dly_q + DLY_W'(1);
                end else begin
                    shift_q <= shift_c;
                    bit_q   <= bit_q + BIT_W'(1);
                    if (done_c) begin
                        active_q   <= 1'b0;
                        hist_valid <= 1'b1;
                        hist_data  <= shift_c;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/branch_pred_driver.sv
// Branch predictor driver: feeds trace records to the predictor, collects
// predictions, reads back the history register and keeps statistics.
// Optional feature: BRANCH_PRED_DRIVER_STATS_EN enables branch/mispredict counters.
module branch_pred_driver
    import branch_pred_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned HIST_BITS      = DEF_HIST_BITS,
    parameter int unsigned HIST_LAT       = DEF_HIST_LAT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_pred_driver_if.master bus,
    input  logic                 hist_start,
    output logic                 hist_valid,
    output logic [HIST_BITS-1:0] hist_data,
    output logic                 result_valid,
    output logic                 result_pred,
    output logic                 result_correct,
    output logic [CNT_W-1:0]     branch_count,
    output logic [CNT_W-1:0]     mispredict_count,
    output logic                 timeout_err,
    output logic                 busy
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]      rst_sync_q;
    logic            rst_int_n;
    state_t          state_q, state_d;
    trace_rec_t      rec_q, rec_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            mem_done_q, mem_done_d;
    logic            pred_q, pred_d;
    logic            correct_q, correct_d;
    logic            timeout_q, timeout_d;
    logic            ready_q, ready_d;
    logic            nda_q, nda_d;
    logic            hreq_q, hreq_d;
    logic            rvalid_q, rvalid_d;
    logic            busy_q, busy_d;
    logic            to_expired_c;
    logic            hist_go_c;
    logic            hist_done_c;

    // Reset deassertion synchroniser; assertion stays asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    assign to_expired_c = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Next state, captured record/prediction and registered output values.
    always_comb begin
        state_d    = state_q;
        rec_d      = rec_q;
        pred_d     = pred_q;
        correct_d  = correct_q;
        mem_done_d = mem_done_q | bus.bp_mem_reset_done;
        timeout_d  = timeout_q;
        hist_go_c  = 1'b0;
        case (state_q)
            ST_WAIT_MEM: if (mem_done_d) state_d = ST_IDLE;
            ST_IDLE: begin
                if (hist_start) begin
                    state_d   = ST_HIST;
                    hist_go_c = 1'b1;
                end else if (bus.trace_valid && ready_q) begin
                    rec_d   = '{addr: bus.trace_addr, taken: bus.trace_taken};
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: state_d = ST_WAIT_PRED;
            ST_WAIT_PRED: begin
                if (bus.bp_pred_ready) begin
                    pred_d    = bus.bp_prediction;
                    correct_d = (bus.bp_prediction == rec_q.taken);
                    state_d   = bus.bp_training_done ? ST_RELEASE : ST_WAIT_DONE;
                end else if (to_expired_c) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.bp_training_done) begin
                    state_d = ST_RELEASE;
                end else if (to_expired_c) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            ST_HIST:    if (hist_done_c) state_d = ST_IDLE;
            default:    state_d = ST_WAIT_MEM;
        endcase

        if (state_d != state_q)
            to_cnt_d = TO_W'(0);
        else if (state_q == ST_WAIT_PRED || state_q == ST_WAIT_DONE)
            to_cnt_d = to_cnt_q + TO_W'(1);
        else
            to_cnt_d = to_cnt_q;

        ready_d  = (state_d == ST_IDLE);
        nda_d    = (state_d == ST_ASSERT) || (state_d == ST_WAIT_PRED) || (state_d == ST_WAIT_DONE);
        hreq_d   = (state_d == ST_HIST);
        rvalid_d = (state_d == ST_RELEASE);
        busy_d   = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= ST_WAIT_MEM;
            rec_q      <= '0;
            to_cnt_q   <= '0;
            mem_done_q <= 1'b0;
            pred_q     <= 1'b0;
            correct_q  <= 1'b0;
            timeout_q  <= 1'b0;
            ready_q    <= 1'b0;
            nda_q      <= 1'b0;
            hreq_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rec_q      <= rec_d;
            to_cnt_q   <= to_cnt_d;
            mem_done_q <= mem_done_d;
            pred_q     <= pred_d;
            correct_q  <= correct_d;
            timeout_q  <= timeout_d;
            ready_q    <= ready_d;
            nda_q      <= nda_d;
            hreq_q     <= hreq_d;
            rvalid_q   <= rvalid_d;
            busy_q     <= busy_d;
        end
    end

    branch_pred_hist_rx #(
        .HIST_BITS (HIST_BITS),
        .HIST_LAT  (HIST_LAT)
    ) u_hist_rx (
        .clk        (clk),
        .rst_n      (rst_int_n),
        .start      (hist_go_c),
        .hist_bit   (bus.bp_hist_bit),
        .done_c     (hist_done_c),
        .hist_valid (hist_valid),
        .hist_data  (hist_data)
    );

`ifdef BRANCH_PRED_DRIVER_STATS_EN
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] mis_cnt_q;

    // Saturating statistics, counted on each result pulse.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else if (rvalid_q) begin
            br_cnt_q <= sat_inc(br_cnt_q);
            if (!correct_q) mis_cnt_q <= sat_inc(mis_cnt_q);
        end
    end

    assign branch_count     = br_cnt_q;
    assign mispredict_count = mis_cnt_q;
`else
    assign branch_count     = '0;
    assign mispredict_count = '0;
`endif

    assign bus.trace_ready       = ready_q;
    assign bus.bp_inst_addr      = rec_q.addr;
    assign bus.bp_direction      = rec_q.taken;
    assign bus.bp_new_data_avail = nda_q;
    assign bus.bp_hist_req       = hreq_q;
    assign result_valid          = rvalid_q;
    assign result_pred           = pred_q;
    assign result_correct        = correct_q;
    assign timeout_err           = timeout_q;
    assign busy                  = busy_q;

endmodule

// File: tb/tb_branch_pred_driver.sv
// Self-checking bench for branch_pred_driver; the bench also plays the
// trace source and the predictor.
module tb_branch_pred_driver;
    import branch_pred_pkg::*;

    localparam int unsigned TO = DEF_TIMEOUT_CYCLES;
    localparam int unsigned HB = DEF_HIST_BITS;
    localparam int unsigned HL = DEF_HIST_LAT;
`ifdef BRANCH_PRED_DRIVER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hist_start;
    logic          hist_valid;
    logic [HB-1:0] hist_data;
    logic          result_valid;
    logic          result_pred;
    logic          result_correct;
    logic [15:0]   branch_count;
    logic [15:0]   mispredict_count;
    logic          timeout_err;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int exp_br = 0;
    int exp_mis = 0;

    branch_pred_driver_if bus ();

    branch_pred_driver #(
        .TIMEOUT_CYCLES (TO),
        .HIST_BITS      (HB),
        .HIST_LAT       (HL)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus),
        .hist_start       (hist_start),
        .hist_valid       (hist_valid),
        .hist_data        (hist_data),
        .result_valid     (result_valid),
        .result_pred      (result_pred),
        .result_correct   (result_correct),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count),
        .timeout_err      (timeout_err),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit held(input logic [7:0] addr, input logic taken);
        return (bus.bp_inst_addr === addr) && (bus.bp_direction === taken) &&
               (bus.bp_new_data_avail === 1'b1);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk_v({tag, "_ctrl"}, 32'({bus.trace_ready, bus.bp_new_data_avail, bus.bp_hist_req,
                                   hist_valid, result_valid, result_pred, result_correct,
                                   timeout_err, busy}), 32'd0);
        chk_v({tag, "_data"}, 32'({bus.bp_inst_addr, bus.bp_direction, hist_data}), 32'd0);
        chk_v({tag, "_cnt"}, 32'({branch_count, mispredict_count}), 32'd0);
    endtask

    task automatic chk_counts(input string tag);
        chk_v({tag, "_branch_count"}, 32'(branch_count), STATS ? exp_br : 0);
        chk_v({tag, "_mispredict_count"}, 32'(mispredict_count), STATS ? exp_mis : 0);
    endtask

    // Present a record and wait (bounded) until the driver accepts it.
    task automatic send_trace(input logic [7:0] addr, input logic taken);
        int n = 0;
        bus.trace_valid = 1'b1;
        bus.trace_addr  = addr;
        bus.trace_taken = taken;
        while (bus.trace_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk_b("accept_ready", bus.trace_ready, 1'b1);
        step();
        bus.trace_valid = 1'b0;
        bus.trace_addr  = ~addr;
        bus.trace_taken = ~taken;
    endtask

    // One full record: predictor answers lat cycles into WAIT_PRED, training
    // completes gap cycles after the prediction (0 = same cycle).
    task automatic run_record(input logic [7:0] addr, input logic taken, input logic pred,
                              input int lat, input int gap, input bit poke_hist);
        bit hold_ok = 1'b1;
        bit rv_seen = 1'b0;
        bit hreq_seen = 1'b0;
        send_trace(addr, taken);
        chk_b("assert_nda", bus.bp_new_data_avail, 1'b1);
        chk_v("assert_addr", 32'(bus.bp_inst_addr), 32'(addr));
        chk_b("assert_dir", bus.bp_direction, taken);
        chk_b("assert_busy", busy, 1'b1);
        chk_b("assert_ready_low", bus.trace_ready, 1'b0);
        repeat (lat) begin
            hold_ok &= held(addr, taken);
            step();
            rv_seen |= result_valid;
        end
        hold_ok &= held(addr, taken);
        bus.bp_pred_ready    = 1'b1;
        bus.bp_prediction    = pred;
        bus.bp_training_done = (gap == 0);
        step();
        bus.bp_pred_ready    = 1'b0;
        bus.bp_prediction    = ~pred;
        bus.bp_training_done = 1'b0;
        if (gap > 0) begin
            for (int i = 1; i < gap; i++) begin
                rv_seen |= result_valid;
                hold_ok &= held(addr, taken);
                hist_start = poke_hist && (i == 2);
                step();
                hreq_seen |= bus.bp_hist_req | hist_valid;
            end
            hist_start = 1'b0;
            rv_seen |= result_valid;
            hold_ok &= held(addr, taken);
            bus.bp_training_done = 1'b1;
            step();
            bus.bp_training_done = 1'b0;
        end
        chk_b("hold_stable", hold_ok, 1'b1);
        chk_b("early_result", rv_seen, 1'b0);
        chk_b("result_valid", result_valid, 1'b1);
        chk_b("result_pred", result_pred, pred);
        chk_b("result_correct", result_correct, pred == taken);
        chk_b("release_nda_low", bus.bp_new_data_avail, 1'b0);
        if (poke_hist) chk_b("hist_ignored", hreq_seen, 1'b0);
        if (exp_br < 16'hFFFF) exp_br++;
        if (pred != taken && exp_mis < 16'hFFFF) exp_mis++;
        step();
        chk_b("result_pulse_end", result_valid, 1'b0);
        chk_b("idle_ready", bus.trace_ready, 1'b1);
        chk_b("idle_busy", busy, 1'b0);
        chk_counts("rec");
    endtask

    // History readback; optionally offers a record in the same cycle as hist_start.
    task automatic run_hist(input logic [HB-1:0] bits, input bit with_trace);
        logic [HB-1:0] b = bits;
        bit early = 1'b0;
        bit nda_seen = 1'b0;
        chk_b("hist_from_idle", bus.trace_ready, 1'b1);
        hist_start = 1'b1;
        if (with_trace) begin
            bus.trace_valid = 1'b1;
            bus.trace_addr  = 8'($urandom);
            bus.trace_taken = 1'($urandom);
        end
        step();
        hist_start      = 1'b0;
        bus.trace_valid = 1'b0;
        chk_b("hist_req_rise", bus.bp_hist_req, 1'b1);
        chk_b("hist_busy", busy, 1'b1);
        nda_seen = bus.bp_new_data_avail;
        bus.bp_hist_bit = ~b[0];
        for (int i = 1; i < HL; i++) begin
            step();
            early    |= hist_valid;
            nda_seen |= bus.bp_new_data_avail;
        end
        for (int i = 0; i < HB; i++) begin
            bus.bp_hist_bit = b[i];
            step();
            if (i < HB - 1) early |= hist_valid;
            nda_seen |= bus.bp_new_data_avail;
        end
        bus.bp_hist_bit = ~b[HB-1];
        chk_b("hist_valid", hist_valid, 1'b1);
        chk_v("hist_data", 32'(hist_data), 32'(bits));
        chk_b("hist_req_fall", bus.bp_hist_req, 1'b0);
        chk_b("hist_early_valid", early, 1'b0);
        chk_b("hist_no_record", nda_seen, 1'b0);
        step();
        chk_b("hist_valid_pulse", hist_valid, 1'b0);
        chk_b("hist_no_rerequest", bus.bp_hist_req, 1'b0);
        chk_b("hist_back_idle", busy, 1'b0);
    endtask

    // Predictor never finishes: expect timeout_err after exactly TIMEOUT_CYCLES
    // cycles in the waiting state (plus the ASSERT cycle when waiting for a prediction).
    task automatic run_timeout(input bit in_done_state);
        int n = 0;
        bit rv_seen = 1'b0;
        send_trace(8'($urandom), 1'($urandom));
        if (in_done_state) begin
            step();
            bus.bp_pred_ready = 1'b1;
            bus.bp_prediction = 1'($urandom);
            step();
            bus.bp_pred_ready = 1'b0;
        end
        while (timeout_err !== 1'b1 && n < int'(TO) + 20) begin
            step();
            n++;
            rv_seen |= result_valid;
        end
        chk_v(in_done_state ? "timeout_cycles_done" : "timeout_cycles_pred", n,
              in_done_state ? TO : TO + 1);
        chk_b("timeout_no_result", rv_seen, 1'b0);
        chk_b("timeout_nda_low", bus.bp_new_data_avail, 1'b0);
        chk_b("timeout_ready", bus.trace_ready, 1'b1);
        step();
        chk_b("timeout_sticky", timeout_err, 1'b1);
        chk_b("timeout_no_result2", result_valid, 1'b0);
    endtask

    initial begin
        bit ready_seen = 1'b0;
        bit rv_seen = 1'b0;
        rst_n                 = 1'b0;
        hist_start            = 1'b0;
        bus.trace_valid       = 1'b0;
        bus.trace_addr        = 8'h00;
        bus.trace_taken       = 1'b0;
        bus.bp_pred_ready     = 1'b0;
        bus.bp_prediction     = 1'b0;
        bus.bp_training_done  = 1'b0;
        bus.bp_mem_reset_done = 1'b0;
        bus.bp_hist_bit       = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");

        // Startup: no memory-reset-done for 200 cycles keeps the driver closed.
        rst_n = 1'b1;
        repeat (200) begin
            step();
            ready_seen |= bus.trace_ready;
        end
        chk_b("startup_ready_held_low", ready_seen, 1'b0);
        chk_b("startup_busy", busy, 1'b1);
        bus.bp_mem_reset_done = 1'b1;
        step();
        bus.bp_mem_reset_done = 1'b0;
        chk_b("startup_ready", bus.trace_ready, 1'b1);
        chk_b("startup_idle", busy, 1'b0);

        // Correct prediction with immediate training completion.
        run_record(8'h34, 1'b1, 1'b1, 1, 0, 1'b0);
        // Mispredict, training done 12 cycles later, hist_start poked in WAIT_DONE.
        run_record(8'($urandom), 1'b0, 1'b1, 2, 12, 1'b1);
        // History readback, with a competing record that must lose.
        run_hist(8'hB2, 1'b1);

        for (int k = 0; k < 16; k++) begin
            run_record(8'($urandom), 1'($urandom), 1'($urandom),
                       int'($urandom_range(1, 4)), int'($urandom_range(0, 8)), 1'b0);
            if (k % 4 == 3) run_hist(HB'($urandom), 1'($urandom));
        end

        // Timeout waiting for a prediction, then normal traffic resumes.
        run_timeout(1'b0);
        run_record(8'($urandom), 1'($urandom), 1'($urandom), 1, 3, 1'b0);

        // Asynchronous reset while waiting for training completion.
        send_trace(8'hC5, 1'b1);
        step();
        bus.bp_pred_ready = 1'b1;
        bus.bp_prediction = 1'b1;
        step();
        bus.bp_pred_ready = 1'b0;
        repeat (3) step();
        chk_b("pre_reset_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        bus.bp_training_done  = 1'b1;
        bus.bp_mem_reset_done = 1'b1;
        exp_br  = 0;
        exp_mis = 0;
        step();
        rv_seen |= result_valid;
        step();
        rv_seen |= result_valid;
        rst_n = 1'b1;
        step();
        rv_seen |= result_valid;
        chk_b("sync_edge1_closed", bus.trace_ready, 1'b0);
        step();
        rv_seen |= result_valid;
        chk_b("sync_edge2_closed", bus.trace_ready, 1'b0);
        step();
        rv_seen |= result_valid;
        chk_b("sync_first_active", bus.trace_ready, 1'b1);
        bus.bp_training_done  = 1'b0;
        bus.bp_mem_reset_done = 1'b0;
        chk_b("reset_no_result", rv_seen, 1'b0);
        chk_b("reset_timeout_clear", timeout_err, 1'b0);
        chk_counts("after_reset");

        // Timeout waiting for training completion, then traffic and history resume.
        run_timeout(1'b1);
        run_record(8'($urandom), 1'b1, 1'b0, 3, 5, 1'b0);
        run_hist(HB'($urandom), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_pred_driver.md
BRANCH_PRED_DRIVER -- requirements
Module: branch_pred_driver

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 63: max cycles waited for any predictor response.
REQ-002 Parameter HIST_BITS, default 8: history bits read back.
REQ-003 Parameter HIST_LAT, default 2: cycles from bp_hist_req rise to the first history bit on bp_hist_bit.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 trace_valid / trace_ready  in / out  1 / 1  upstream branch-record handshake.
REQ-007 trace_addr  in  8  branch instruction address; trace_taken  in  1  actual outcome.
REQ-008 bp_inst_addr  out  8; bp_direction  out  1; bp_new_data_avail  out  1  drive the predictor.
REQ-009 bp_pred_ready, bp_prediction, bp_training_done, bp_mem_reset_done, bp_hist_bit  in  1 each  predictor status.
REQ-010 bp_hist_req  out  1  history readback request.
REQ-011 hist_start  in  1  readback command pulse; hist_valid  out  1  one-cycle pulse; hist_data  out  HIST_BITS.
REQ-012 result_valid  out  1  pulse; result_pred  out  1; result_correct  out  1.
REQ-013 branch_count, mispredict_count  out  16 each; timeout_err  out  1 sticky; busy  out  1.

Function
REQ-014 States: WAIT_MEM, IDLE, ASSERT, WAIT_PRED, WAIT_DONE, RELEASE, HIST.
REQ-015 WAIT_MEM: trace_ready=0 until a bp_mem_reset_done pulse is seen, then IDLE; the pulse is latched into a sticky flag.
REQ-016 IDLE: trace_ready=1; a transfer occurs on trace_valid&trace_ready; the driver registers addr/taken onto bp_inst_addr/bp_direction and enters ASSERT.
REQ-017 ASSERT: bp_new_data_avail=1 (registered); next cycle WAIT_PRED.
REQ-018 WAIT_PRED: on bp_pred_ready=1, capture bp_prediction; if bp_training_done is also 1 in that cycle, go to RELEASE, else go to WAIT_DONE.
REQ-019 WAIT_DONE: on bp_training_done=1, go to RELEASE.
REQ-020 bp_inst_addr and bp_direction SHALL remain stable from ASSERT through the cycle in which bp_training_done is sampled.
REQ-021 RELEASE: bp_new_data_avail=0 for exactly one cycle; result_valid pulses with result_pred=captured prediction and result_correct=(prediction==direction); then IDLE.
REQ-022 Back-to-back trace records: new_data_avail low time SHALL be >=1 cycle, so every record produces a fresh rising edge.
REQ-023 Timeout: a counter runs in WAIT_PRED/WAIT_DONE and clears on each state entry; on reaching TIMEOUT_CYCLES, set timeout_err, drop bp_new_data_avail, suppress result_valid, return to IDLE.
REQ-024 hist_start is honoured only in IDLE, and takes priority over a simultaneous trace_valid; it is ignored in other states.
REQ-025 HIST: bp_hist_req=1; sample bp_hist_bit starting HIST_LAT cycles after the rise, for HIST_BITS consecutive cycles; the first bit goes into hist_data[0].
REQ-026 After the last bit: hist_valid pulses for one cycle, bp_hist_req=0, return to IDLE; a new request needs a fresh hist_start.
REQ-027 busy=1 in every state except IDLE.
REQ-028 Counters saturate at 16'hFFFF; branch_count increments on result_valid; mispredict_count increments on result_valid&~result_correct.

Reset
REQ-029 Async assert: state=WAIT_MEM; all outputs 0; counters 0; timeout_err=0; sticky mem-done flag=0.
REQ-030 Reset mid-transaction abandons it, with no result_valid and no hist_valid.
REQ-031 Deassertion is synchronised internally; the first active edge follows two clk edges after rst_n rises.

Configuration
REQ-032 Macro BRANCH_PRED_DRIVER_STATS_EN: when defined, branch_count and mispredict_count are implemented per REQ-028; when undefined, both are tied to 0 and no counter flops exist.

Structure
REQ-033 Package branch_pred_pkg: state enum, address width 8, counter width 16, default parameter constants.
REQ-034 Sub-module branch_pred_hist_rx: the HIST_LAT delay counter, bit counter, shift register and hist_valid generation; started by the top FSM.

Verification
REQ-035 Startup: hold bp_mem_reset_done=0 for 200 cycles -> trace_ready stays 0; pulse it -> trace_ready=1 next cycle.
REQ-036 Correct prediction: addr=8'h34, taken=1; model asserts pred_ready+training_done in the same cycle with prediction=1 -> result_valid, result_correct=1, branch_count=1, mispredict_count=0.
REQ-037 Mispredict: taken=0, prediction=1, training_done 12 cycles after pred_ready -> bp_direction held 0 throughout; result_correct=0; mispredict_count=1.
REQ-038 Timeout: model never responds -> timeout_err=1 at TIMEOUT_CYCLES, no result_valid, next record accepted.
REQ-039 History: model shifts 8'b1011_0010 LSB-first at HIST_LAT -> hist_valid with hist_data=8'hB2; hist_start during WAIT_DONE is ignored.
REQ-040 Async reset asserted in WAIT_DONE -> outputs 0 immediately, state WAIT_MEM, no result_valid.
